// File: rtl/cdc_handshake_tx_if.sv
// Producer-side bus and destination-side request/acknowledge lines of the
// 4-phase handshake transmitter.
interface cdc_handshake_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             req;
   logic [WIDTH-1:0] tx_data;
   logic             ack_async;
   logic             done;
   logic             busy;
   logic             timeout_err;

   modport master (
      input  in_valid, in_data, ack_async,
      output in_ready, req, tx_data, done, busy, timeout_err
   );

   modport slave (
      output in_valid, in_data, ack_async,
      input  in_ready, req, tx_data, done, busy, timeout_err
   );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source half of a 4-phase req/ack clock-domain crossing: captures a word,
// holds it on tx_data under a registered req and waits for the synchronized ack.
module cdc_handshake_tx #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                clk,
   input  logic                rst,
   cdc_handshake_tx_if.master  bus
);
   localparam int unsigned    CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      REQ_HI,
      WAIT_ACK_LO
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
   logic                   req_q, req_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   done_q, done_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   in_ready;

   assign ack_s    = sync_q[SYNC_STAGES-1];
   assign in_ready = (state_q == IDLE) && !ack_s;

   assign bus.in_ready    = in_ready;
   assign bus.req         = req_q;
   assign bus.tx_data     = data_q;
   assign bus.done        = done_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.timeout_err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sync_q  <= '0;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.ack_async};
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.in_valid && in_ready) begin
               data_d  = bus.in_data;
               req_d   = 1'b1;
               state_d = REQ_HI;
            end
         end
         REQ_HI, WAIT_ACK_LO: begin
            if ((state_q == REQ_HI) && ack_s) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = WAIT_ACK_LO;
            end else if ((state_q == WAIT_ACK_LO) && !ack_s) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if ((TIMEOUT != 0) && (cnt_q != TO_MAX)) begin
               // Saturating wait counter; the error latches on the cycle it tops out.
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == TO_MAX) begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: accepted words go into a scoreboard
// queue that a done-pulse monitor pops and compares against tx_data.
module tb_cdc_handshake_tx;
   logic clk = 1'b0;
   logic rst;
   logic man_ack;
   logic auto_rx;
   logic rx_ack = 1'b0;
   logic rs1 = 1'b0, rs2 = 1'b0;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned done_cnt = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_got[$];

   always #5 clk = ~clk;

   cdc_handshake_tx_if #(.WIDTH(8)) bus ();

   assign bus.ack_async = auto_rx ? rx_ack : man_ack;

   cdc_handshake_tx #(
      .WIDTH       (8),
      .SYNC_STAGES (2),
      .TIMEOUT     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic val, input string nm);
      int k = 0;
      while (bus.req !== val && k < 100) begin
         tick();
         k++;
      end
      chk(nm, 32'(bus.req), 32'(val));
   endtask

   task automatic wait_done(input int unsigned target, input string nm);
      int k = 0;
      while (done_cnt < target && k < 200) begin
         tick();
         k++;
      end
      chk(nm, 32'(done_cnt >= target), 32'd1);
   endtask

   // Destination model: two-flop req synchronizer, captures on rising synchronized req.
   always @(posedge clk) begin
      rs1 <= bus.req;
      rs2 <= rs1;
      if (auto_rx) begin
         if (rs2 && !rx_ack) begin
            rx_ack <= 1'b1;
            rx_got.push_back(bus.tx_data);
         end else if (!rs2 && rx_ack) begin
            rx_ack <= 1'b0;
         end
      end else begin
         rx_ack <= 1'b0;
      end
   end

   // Scoreboard monitor: each done pulse retires one expected word.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("done_without_expected", 32'd1, 32'd0);
         end else begin
            chk("done_tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      rst          = 1'b1;
      man_ack      = 1'b1;
      auto_rx      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h3C;

      // Reset held with ack and valid asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_req", 32'(bus.req), 32'd0);
         chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
         chk("rst_done", 32'(bus.done), 32'd0);
         chk("rst_err", 32'(bus.timeout_err), 32'd0);
         chk("rst_busy", 32'(bus.busy), 32'd0);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("stale_ack_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stale_ack_no_req", 32'(bus.req), 32'd0);
         chk("stale_ack_ready_hold", 32'(bus.in_ready), 32'd0);
      end
      man_ack      = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("ready_after_drain", 32'(bus.in_ready), 32'd1);

      // Single transfer, edge-exact timing
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      exp_q.push_back(8'hA5);
      tick();                                      // edge 0
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      chk("single_req_e0", 32'(bus.req), 32'd1);
      chk("single_busy_e0", 32'(bus.busy), 32'd1);
      chk("single_data_e0", 32'(bus.tx_data), 32'hA5);
      chk("single_ready_e0", 32'(bus.in_ready), 32'd0);
      tick();
      tick();                                      // edge 2
      man_ack = 1'b1;
      tick();
      tick();                                      // edge 4
      chk("single_req_e4", 32'(bus.req), 32'd1);
      tick();                                      // edge 5
      chk("single_req_e5", 32'(bus.req), 32'd0);
      chk("single_data_e5", 32'(bus.tx_data), 32'hA5);
      man_ack = 1'b0;
      tick();
      tick();                                      // edge 7
      chk("single_done_e7", 32'(bus.done), 32'd0);
      chk("single_busy_e7", 32'(bus.busy), 32'd1);
      tick();                                      // edge 8
      chk("single_done_e8", 32'(bus.done), 32'd1);
      chk("single_busy_e8", 32'(bus.busy), 32'd0);
      chk("single_ready_e8", 32'(bus.in_ready), 32'd1);
      tick();                                      // edge 9
      chk("single_done_e9", 32'(bus.done), 32'd0);

      // Input changes while busy are ignored
      base         = done_cnt;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      exp_q.push_back(8'h5A);
      tick();
      bus.in_data = 8'hFF;
      tick();
      tick();
      chk("busy_ignore_data", 32'(bus.tx_data), 32'h5A);
      chk("busy_ignore_req", 32'(bus.req), 32'd1);
      man_ack      = 1'b1;
      bus.in_valid = 1'b0;
      wait_req(1'b0, "busy_req_fall");
      chk("busy_ignore_data2", 32'(bus.tx_data), 32'h5A);
      man_ack = 1'b0;
      wait_done(base + 1, "busy_done_seen");
      repeat (8) tick();
      chk("busy_single_done", done_cnt - base, 32'd1);

      // Back-to-back transfers against the destination model
      auto_rx = 1'b1;
      base    = done_cnt;
      rx_got.delete();
      for (int i = 1; i <= 4; i++) begin
         int k = 0;
         bus.in_data  = 8'(i);
         bus.in_valid = 1'b1;
         exp_q.push_back(8'(i));
         while (!bus.in_ready && k < 100) begin
            tick();
            k++;
         end
         chk("b2b_ready_seen", 32'(bus.in_ready), 32'd1);
         tick();
      end
      bus.in_valid = 1'b0;
      wait_done(base + 4, "b2b_done_seen");
      repeat (10) tick();
      auto_rx = 1'b0;
      chk("b2b_done_count", done_cnt - base, 32'd4);
      chk("b2b_rx_count", rx_got.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] got;
         got = (i < rx_got.size()) ? rx_got[i] : 8'hxx;
         chk("b2b_rx_word", 32'(got), 32'(i + 1));
      end

      // Timeout with ack withheld
      base         = done_cnt;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      exp_q.push_back(8'h77);
      tick();                                      // accept edge E
      bus.in_valid = 1'b0;
      repeat (15) tick();                          // E+15
      chk("timeout_err_e15", 32'(bus.timeout_err), 32'd0);
      tick();                                      // E+16
      chk("timeout_err_e16", 32'(bus.timeout_err), 32'd1);
      chk("timeout_req_held", 32'(bus.req), 32'd1);
      repeat (5) tick();
      chk("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
      man_ack = 1'b1;
      wait_req(1'b0, "timeout_req_fall");
      man_ack = 1'b0;
      wait_done(base + 1, "timeout_done_seen");
      tick();
      chk("timeout_err_after_done", 32'(bus.timeout_err), 32'd1);

      // Reset in WAIT_ACK_LO with ack still high
      base         = done_cnt;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h99;
      exp_q.push_back(8'h99);
      tick();
      bus.in_valid = 1'b0;
      man_ack      = 1'b1;
      wait_req(1'b0, "midrst_req_fall");
      chk("midrst_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_req", 32'(bus.req), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_tx_data", 32'(bus.tx_data), 32'h0);
      chk("midrst_err_cleared", 32'(bus.timeout_err), 32'd0);
      tick();
      tick();
      chk("midrst_no_done", done_cnt - base, 32'd0);
      chk("midrst_pending", exp_q.size(), 32'd1);
      exp_q.delete();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h42;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midrst_refused", 32'(bus.req), 32'd0);
      end
      man_ack = 1'b0;                              // before edge X+1
      tick();                                      // X+1
      chk("midrst_ready_x1", 32'(bus.in_ready), 32'd0);
      tick();                                      // X+2
      chk("midrst_ready_x2", 32'(bus.in_ready), 32'd1);
      exp_q.push_back(8'h42);
      tick();                                      // accept
      bus.in_valid = 1'b0;
      chk("midrst_accept_req", 32'(bus.req), 32'd1);
      chk("midrst_accept_data", 32'(bus.tx_data), 32'h42);
      man_ack = 1'b1;
      wait_req(1'b0, "midrst_req_fall2");
      man_ack = 1'b0;
      wait_done(base + 1, "midrst_done_seen");
      repeat (4) tick();
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side (transmitter) half of a 4-phase req/ack handshake used to move a multi-bit word from this clock domain into an unrelated one. It captures a word from a valid/ready producer, holds it stable on `tx_data`, and drives a registered `req`. The returned `ack_async` is brought in through an internal flip-flop synchronizer chain. The block pairs with a destination-side receiver that samples `tx_data` once its synchronized `req` is high.

## Interface
- `WIDTH`, 8: payload width in bits.
- `SYNC_STAGES`, 2: flops in the `ack_async` synchronizer chain; legal values are 2 or more.
- `TIMEOUT`, 1024: cycles without a handshake edge, while a transfer is in flight, before `timeout_err` sets. 0 disables the check.

Ports:
- `clk` in 1: sole clock. All logic is on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: producer has a word.
- `in_data` in WIDTH: producer word.
- `in_ready` out 1: block can accept a word. Combinational: `(state==IDLE) && !ack_s`.
- `req` out 1: registered request to the destination domain.
- `tx_data` out WIDTH: registered payload. Stable whenever `req`=1 or `ack_s`=1.
- `ack_async` in 1: acknowledge from the destination domain. Asynchronous to `clk`.
- `done` out 1: single-cycle pulse when a 4-phase cycle completes.
- `busy` out 1: `state != IDLE`.
- `timeout_err` out 1: sticky error flag. Cleared only by `rst`.

## Operation
- `ack_async` passes through a SYNC_STAGES-deep flop chain. The last stage is `ack_s`. No other logic samples `ack_async`.
- FSM states:
  - **IDLE**: `req`=0.
    - On `in_valid && in_ready`: load `tx_data`<=`in_data`, set `req`<=1, move to REQ_HI.
    - Stay in IDLE while `ack_s`=1. A stale ack, for example after a reset mid-transfer, must drain before a new accept.
  - **REQ_HI**: `req`=1, `tx_data` frozen.
    - On `ack_s`=1: `req`<=0, move to WAIT_ACK_LO.
  - **WAIT_ACK_LO**: `req`=0, `tx_data` still frozen.
    - On `ack_s`=0: move to IDLE, `done`<=1 for one cycle.
- `in_data` is ignored unless an accept occurs. `in_valid` while busy has no effect.
- Timeout:
  - A counter clears on entry to REQ_HI and WAIT_ACK_LO, and increments each cycle spent in either state.
  - When it reaches TIMEOUT, `timeout_err`<=1 and the counter saturates.
  - The FSM keeps waiting; the protocol is never abandoned.
  - The counter is held at 0 in IDLE.
- Reset, with `rst`=1 sampled at an edge:
  - After that edge: `req`=0, `tx_data`=0, sync chain=0, state=IDLE, `done`=0, `busy`=0, `timeout_err`=0, counter=0.
  - Reset overrides any simultaneous accept.

## Timing
- Accept at edge E (`in_valid`=1, `in_ready`=1): `req`=1, `tx_data` valid and `busy`=1 after E.
- `ack_async` rising before edge A makes `ack_s`=1 after edge A+SYNC_STAGES-1.
- REQ_HI sees `ack_s`=1 at edge F: `req`=0 after F.
- WAIT_ACK_LO sees `ack_s`=0 at edge G: `done`=1 and `busy`=0 after G. `done` clears after G+1.
- `in_ready` can be high in the same cycle as `done`, so back-to-back accepts are allowed with no gap cycle.
- Minimum cycle with an instant-responding destination is bounded by 2×SYNC_STAGES plus the destination's own sync latency. The block adds no extra wait states beyond one registered edge per transition.
- `tx_data` changes only on an accept edge or reset.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles while `ack_async`=1 and `in_valid`=1 -> `req`=0, `tx_data`=0, `done`=0, `timeout_err`=0. After release, `in_ready`=0 until `ack_s`=0.
- **Single transfer (SYNC_STAGES=2):**
  - Accept 0xA5 at edge 0 -> `req`=1 after edge 0.
  - Bench raises `ack_async` before edge 3 -> `req`=0 after edge 5.
  - Bench drops ack before edge 6 -> `done`=1 after edge 8, and `tx_data`=0xA5 throughout.
- **Back-to-back:** 4 words 0x01..0x04 with `in_valid` held high, against a bench receiver -> receiver captures 0x01..0x04 in order, exactly 4 `done` pulses, no word lost or duplicated.
- **Ignore while busy:** change `in_data` to 0xFF with `in_valid`=1 during REQ_HI -> `tx_data` stays at the accepted value, and only one `done` pulse occurs.
- **Timeout (TIMEOUT=16):** accept a word, never ack -> `timeout_err`=1 after 16 cycles in REQ_HI and `req` stays 1. Ack arriving later still completes the cycle with `done`=1, and `timeout_err` stays 1.
- **Reset mid-transfer:** assert `rst` in WAIT_ACK_LO with `ack_async` still 1 -> `req`=0 and no `done`. After release, an accept is refused until `ack_async` falls and SYNC_STAGES edges elapse.
